md_unit: RTL and testbench

Multiply/divide unit for the EX stage of the five-stage pipeline. It takes the two forwarded operands from the EX-stage 32-bit forwarding multiplexers and runs multi-cycle signed or unsigned multiply and divide, plus direct HI/LO writes. It holds results in internal HI/LO registers and reports `Busy` so the hazard logic can stall dependent `mfhi`/`mflo` and further MD instructions.

---
 rtl/md_pkg.sv | 21 ++
 rtl/md_calc.sv | 78 +++++++
 rtl/md_unit.sv | 108 ++++++++++
 tb/tb_md_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp encodings,
// FSM state encodings and default latencies.
package md_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam int MD_MUL_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF = 10;

endpackage

// File: rtl/md_calc.sv
// Combinational datapath of the multiply/divide unit. Produces the 64-bit
// {HI,LO} result for the latched operation and a write enable that is low
// for divide by zero. Optional MADD accumulate is built when MDU_MADD_EN
// is defined.
module md_calc
    import md_pkg::*;
(
    input  logic [31:0] i_opA,
    input  logic [31:0] i_opB,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_result,
    output logic        o_we
);

    logic [63:0] w_prodS;
    logic [63:0] w_prodU;
    logic        w_signedDiv;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [31:0] w_divisor;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_quoNeg;
    logic        w_remNeg;

    // The low 64 bits of a product of sign-extended operands equal the signed product
    assign w_prodS = {{32{i_opA[31]}}, i_opA} * {{32{i_opB[31]}}, i_opB};
    assign w_prodU = {32'd0, i_opA} * {32'd0, i_opB};

    // Signed divide works on magnitudes, then restores signs; this also makes
    // 0x80000000 / -1 come out as 0x80000000 with no special case
    assign w_signedDiv = (i_op == OP_DIV);
    assign w_absA      = (w_signedDiv && i_opA[31]) ? -i_opA : i_opA;
    assign w_absB      = (w_signedDiv && i_opB[31]) ? -i_opB : i_opB;
    assign w_divisor   = (w_absB == 32'd0) ? 32'd1 : w_absB;
    assign w_quo       = w_absA / w_divisor;
    assign w_rem       = w_absA % w_divisor;
    assign w_quoNeg    = w_signedDiv && (i_opA[31] ^ i_opB[31]);
    assign w_remNeg    = w_signedDiv && i_opA[31];

`ifdef MDU_MADD_EN
    logic [63:0] w_madd;
    assign w_madd = {i_hi, i_lo} + w_prodS;
`endif

    // Select the result for the latched op; unknown ops leave HI/LO as they are
    always_comb begin
        o_result = {i_hi, i_lo};
        o_we     = 1'b0;
        case (i_op)
            OP_MULT: begin
                o_result = w_prodS;
                o_we     = 1'b1;
            end
            OP_MULTU: begin
                o_result = w_prodU;
                o_we     = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                o_result = {(w_remNeg ? -w_rem : w_rem), (w_quoNeg ? -w_quo : w_quo)};
                o_we     = (i_opB != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                o_result = w_madd;
                o_we     = 1'b1;
            end
`endif
            default: begin
                o_result = {i_hi, i_lo};
                o_we     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: FSM, latency counter, operand latches and
// HI/LO registers. The MADD accumulate op is enabled by defining MDU_MADD_EN;
// otherwise MDOp 7 behaves as NONE.
module md_unit
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = MD_MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_CNT_INIT = 4'(DIV_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [2:0]  r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] w_result;
    logic        w_we;

    md_calc u_calc (
        .i_opA    (r_opA),
        .i_opB    (r_opB),
        .i_op     (r_op),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .o_result (w_result),
        .o_we     (w_we)
    );

    // Accept new ops only in IDLE, count down the latency, and commit HI/LO on the last busy cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_opA   <= 32'd0;
            r_opB   <= 32'd0;
            r_op    <= OP_NONE;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            OP_MULT, OP_MULTU: begin
                                r_opA   <= A;
                                r_opB   <= B;
                                r_op    <= MDOp;
                                r_cnt   <= MUL_CNT_INIT;
                                r_state <= ST_MUL;
                            end
`ifdef MDU_MADD_EN
                            OP_MADD: begin
                                r_opA   <= A;
                                r_opB   <= B;
                                r_op    <= MDOp;
                                r_cnt   <= MUL_CNT_INIT;
                                r_state <= ST_MUL;
                            end
`endif
                            OP_DIV, OP_DIVU: begin
                                r_opA   <= A;
                                r_opB   <= B;
                                r_op    <= MDOp;
                                r_cnt   <= DIV_CNT_INIT;
                                r_state <= ST_DIV;
                            end
                            OP_MTHI: r_hi <= A;
                            OP_MTLO: r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (r_cnt == 4'd0) begin
                        if (w_we) begin
                            r_hi <= w_result[63:32];
                            r_lo <= w_result[31:0];
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Busy = (r_state != ST_IDLE);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases followed by random
// operations, all compared against an arithmetic model of HI/LO.
// Define MDU_MADD_EN to exercise the MADD accumulate path.
module tb_md_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_MULT  = 3'd1;
    localparam logic [2:0] T_MULTU = 3'd2;
    localparam logic [2:0] T_DIV   = 3'd3;
    localparam logic [2:0] T_DIVU  = 3'd4;
    localparam logic [2:0] T_MTHI  = 3'd5;
    localparam logic [2:0] T_MTLO  = 3'd6;
    localparam logic [2:0] T_MADD  = 3'd7;

    logic        clk;
    logic        resetN;
    logic [31:0] A;
    logic [31:0] B;
    logic        Start;
    logic [2:0]  MDOp;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int nAsserts = 0;
    int nFail    = 0;

    logic [31:0] mHi;
    logic [31:0] mLo;

    md_unit #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (resetN),
        .A     (A),
        .B     (B),
        .Start (Start),
        .MDOp  (MDOp),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs outside the bounded loops
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Arithmetic model of what HI/LO hold after an op completes
    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int                sa;
        int                sb;
        longint            sp;
        longint unsigned   up;
        longint unsigned   acc;
        sa = a;
        sb = b;
        case (op)
            T_MULT: begin
                sp  = longint'(sa) * longint'(sb);
                mHi = sp[63:32];
                mLo = sp[31:0];
            end
            T_MULTU: begin
                up  = longint'({32'd0, a}) * longint'({32'd0, b});
                mHi = up[63:32];
                mLo = up[31:0];
            end
            T_DIV: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        mLo = 32'h8000_0000;
                        mHi = 32'd0;
                    end else begin
                        mLo = sa / sb;
                        mHi = sa % sb;
                    end
                end
            end
            T_DIVU: begin
                if (b != 32'd0) begin
                    mLo = a / b;
                    mHi = a % b;
                end
            end
            T_MTHI: mHi = a;
            T_MTLO: mLo = a;
`ifdef MDU_MADD_EN
            T_MADD: begin
                sp  = longint'(sa) * longint'(sb);
                acc = {mHi, mLo};
                acc = acc + sp;
                mHi = acc[63:32];
                mLo = acc[31:0];
            end
`endif
            default: ;
        endcase
    endtask

    function automatic int expectedBusy(input logic [2:0] op);
        case (op)
            T_MULT, T_MULTU: return MUL_N;
            T_DIV, T_DIVU:   return DIV_N;
`ifdef MDU_MADD_EN
            T_MADD:          return MUL_N;
`endif
            default:         return 0;
        endcase
    endfunction

    // Called just after a negedge: holds Start for one cycle, then scrambles A/B
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
        MDOp  = T_NONE;
        A     = $urandom;
        B     = $urandom;
    endtask

    // Issue one op, count Busy cycles, check HI/LO hold while busy, then check the result
    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] prevHi;
        logic [31:0] prevLo;
        int          busyCount;
        prevHi    = mHi;
        prevLo    = mLo;
        busyCount = 0;
        applyStimulus(op, a, b);
        while (Busy !== 1'b0 && busyCount < 40) begin
            checkOutput({tag, "_hiHold"}, HI, prevHi);
            checkOutput({tag, "_loHold"}, LO, prevLo);
            busyCount++;
            @(negedge clk);
        end
        checkOutput({tag, "_busyCycles"}, 32'(busyCount), 32'(expectedBusy(op)));
        modelOp(op, a, b);
        checkOutput({tag, "_HI"}, HI, mHi);
        checkOutput({tag, "_LO"}, LO, mLo);
    endtask

    logic [2:0]  opList [6];
    logic [2:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;

    initial begin
        opList = '{T_MULT, T_MULTU, T_DIV, T_DIVU, T_MTHI, T_MTLO};
        resetN = 1'b0;
        Start  = 1'b0;
        MDOp   = T_NONE;
        A      = 32'd0;
        B      = 32'd0;
        mHi    = 32'd0;
        mLo    = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_Busy", {31'd0, Busy}, 32'd0);
        checkOutput("rst_HI", HI, 32'd0);
        checkOutput("rst_LO", LO, 32'd0);
        resetN = 1'b1;
        @(negedge clk);

        // Directed cases, issued back to back
        runOp("mult", T_MULT, 32'hFFFF_FFFE, 32'd3);
        checkOutput("mult_HIconst", HI, 32'hFFFF_FFFF);
        checkOutput("mult_LOconst", LO, 32'hFFFF_FFFA);
        runOp("multu", T_MULTU, 32'hFFFF_FFFF, 32'd2);
        checkOutput("multu_HIconst", HI, 32'h0000_0001);
        checkOutput("multu_LOconst", LO, 32'hFFFF_FFFE);
        runOp("div", T_DIV, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div_LOconst", LO, 32'hFFFF_FFFD);
        checkOutput("div_HIconst", HI, 32'hFFFF_FFFF);
        runOp("mthi", T_MTHI, 32'h0000_1234, 32'd0);
        runOp("mtlo", T_MTLO, 32'h0000_5678, 32'd0);
        runOp("divu0", T_DIVU, 32'd5, 32'd0);
        checkOutput("divu0_HIconst", HI, 32'h0000_1234);
        checkOutput("divu0_LOconst", LO, 32'h0000_5678);
        runOp("div0s", T_DIV, 32'hFFFF_FF00, 32'd0);
        runOp("divOvf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("divOvf_LOconst", LO, 32'h8000_0000);
        checkOutput("divOvf_HIconst", HI, 32'd0);
        runOp("divPosNeg", T_DIV, 32'd7, 32'hFFFF_FFFE);

        // Random operations against the model
        for (int i = 0; i < 16; i++) begin
            rOp = opList[$urandom_range(0, 5)];
            rA  = $urandom;
            rB  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rB = 32'($urandom_range(1, 9));
            runOp("rand", rOp, rA, rB);
        end

        // Abort a divide with reset; a stray MTLO while busy must be ignored
        runOp("preAbort", T_MTHI, 32'hDEAD_BEEF, 32'd0);
        applyStimulus(T_DIV, 32'd100, 32'd7);
        @(negedge clk);
        Start = 1'b1;
        MDOp  = T_MTLO;
        A     = 32'h0000_AAAA;
        @(negedge clk);
        Start = 1'b0;
        MDOp  = T_NONE;
        checkOutput("abort_mtloIgnored", LO, mLo);
        checkOutput("abort_stillBusy", {31'd0, Busy}, 32'd1);
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        mHi = 32'd0;
        mLo = 32'd0;
        checkOutput("abort_Busy", {31'd0, Busy}, 32'd0);
        checkOutput("abort_HI", HI, 32'd0);
        checkOutput("abort_LO", LO, 32'd0);
        repeat (DIV_N + 4) @(negedge clk);
        checkOutput("abort_noLateHI", HI, 32'd0);
        checkOutput("abort_noLateLO", LO, 32'd0);

`ifdef MDU_MADD_EN
        runOp("maddSetHi", T_MTHI, 32'd0, 32'd0);
        runOp("maddSetLo", T_MTLO, 32'd10, 32'd0);
        runOp("madd1", T_MADD, 32'd3, 32'd4);
        checkOutput("madd1_LOconst", LO, 32'd22);
        checkOutput("madd1_HIconst", HI, 32'd0);
        runOp("madd2", T_MADD, 32'hFFFF_FFFF, 32'd30);
        checkOutput("madd2_HIconst", HI, 32'hFFFF_FFFF);
        checkOutput("madd2_LOconst", LO, 32'hFFFF_FFF8);
`else
        runOp("op7SetHi", T_MTHI, 32'h0000_0042, 32'd0);
        runOp("op7SetLo", T_MTLO, 32'h0000_0099, 32'd0);
        runOp("op7", T_MADD, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        checkOutput("op7_Busy", {31'd0, Busy}, 32'd0);
        checkOutput("op7_HI", HI, 32'h0000_0042);
        checkOutput("op7_LO", LO, 32'h0000_0099);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
